floo_nw_split: RTL and testbench



---
 rtl/floo_nw_split.sv | 248 ++++++++++++++++++++++++
 tb/tb_floo_nw_split.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_nw_split.sv
`default_nettype none
// ============================================================================
// Module      : floo_nw_split
// Description : Steers one AXI manager stream to a narrow or a wide chimney
//               port by address window and merges B/R back in order. Order
//               is kept by allowing outstanding transactions of a channel
//               class to target only one side at a time.
// Revision    : 1.0 - initial release
// ============================================================================

package floo_nw_split_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [47:0] addr;
      logic [7:0]  len;
      logic [5:0]  atop;
   } aw_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [47:0] addr;
      logic [7:0]  len;
   } ar_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;

endpackage

module floo_nw_split #(
   parameter int unsigned           ADDR_WIDTH   = 48,
   parameter logic [ADDR_WIDTH-1:0] WIDE_START   = '0,
   parameter logic [ADDR_WIDTH-1:0] WIDE_END     = '0,
   parameter int unsigned           MAX_TXNS     = 8,
   parameter int unsigned           W_FIFO_DEPTH = 4,
   parameter type                   AXI_REQ_T    = floo_nw_split_pkg::axi_req_t,
   parameter type                   AXI_RSP_T    = floo_nw_split_pkg::axi_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  AXI_REQ_T slv_req_i,
   output AXI_RSP_T slv_rsp_o,
   output AXI_REQ_T narrow_req_o,
   input  AXI_RSP_T narrow_rsp_i,
   output AXI_REQ_T wide_req_o,
   input  AXI_RSP_T wide_rsp_i
);

   localparam int unsigned c_cnt_w  = $clog2(MAX_TXNS + 1);
   localparam int unsigned c_fcnt_w = $clog2(W_FIFO_DEPTH + 1);
   localparam int unsigned c_ptr_w  = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;

   localparam logic [c_cnt_w-1:0]  c_max_txns   = c_cnt_w'(MAX_TXNS);
   localparam logic [c_fcnt_w-1:0] c_fifo_depth = c_fcnt_w'(W_FIFO_DEPTH);
   localparam logic [c_ptr_w-1:0]  c_ptr_last   = c_ptr_w'(W_FIFO_DEPTH - 1);
   localparam logic                c_narrow     = 1'b0;
   localparam logic                c_wide       = 1'b1;

   // State
   logic [c_cnt_w-1:0]      r_w_cnt, r_r_cnt;
   logic                    r_w_dir, r_r_dir;
   logic [W_FIFO_DEPTH-1:0] r_fifo_mem;
   logic [c_ptr_w-1:0]      r_fifo_wr, r_fifo_rd;
   logic [c_fcnt_w-1:0]     r_fifo_cnt;

   // Decode and handshake wires
   logic [ADDR_WIDTH-1:0] w_aw_addr, w_ar_addr;
   logic w_aw_tgt, w_ar_tgt, w_aw_atop_rd;
   logic w_aw_stall, w_ar_stall;
   logic w_aw_ready, w_ar_ready, w_w_ready;
   logic w_fifo_empty, w_fifo_full, w_w_head;
   logic w_b_valid, w_r_valid, w_r_last;
   logic w_aw_hs, w_ar_hs, w_w_pop, w_b_hs, w_r_done;
   logic w_r_inc;

   assign w_aw_addr    = slv_req_i.aw.addr[ADDR_WIDTH-1:0];
   assign w_ar_addr    = slv_req_i.ar.addr[ADDR_WIDTH-1:0];
   assign w_aw_atop_rd = slv_req_i.aw.atop[5];

   // Atomics always go narrow so their read response stays on one side.
   assign w_aw_tgt = (w_aw_addr >= WIDE_START) && (w_aw_addr < WIDE_END)
                     && (slv_req_i.aw.atop == '0);
   assign w_ar_tgt = (w_ar_addr >= WIDE_START) && (w_ar_addr < WIDE_END);

   assign w_fifo_empty = (r_fifo_cnt == '0);
   assign w_fifo_full  = (r_fifo_cnt == c_fifo_depth);
   assign w_w_head     = r_fifo_mem[r_fifo_rd];

   assign w_aw_stall = (r_w_cnt == c_max_txns) || w_fifo_full
                       || ((w_aw_tgt != r_w_dir) && (r_w_cnt != '0))
                       || (w_aw_atop_rd && ((r_r_cnt == c_max_txns)
                           || ((r_r_dir == c_wide) && (r_r_cnt != '0))));

   // An ATOP with a read response also claims the read counter; holding AR
   // off in that cycle keeps the read counter to a single increment and lets
   // the ATOP set the read direction unambiguously.
   assign w_ar_stall = (r_r_cnt == c_max_txns)
                       || ((w_ar_tgt != r_r_dir) && (r_r_cnt != '0))
                       || (slv_req_i.aw_valid && w_aw_atop_rd);

   assign w_aw_ready = !w_aw_stall
                       && ((w_aw_tgt == c_wide) ? wide_rsp_i.aw_ready : narrow_rsp_i.aw_ready);
   assign w_ar_ready = !w_ar_stall
                       && ((w_ar_tgt == c_wide) ? wide_rsp_i.ar_ready : narrow_rsp_i.ar_ready);
   assign w_w_ready  = !w_fifo_empty
                       && ((w_w_head == c_wide) ? wide_rsp_i.w_ready : narrow_rsp_i.w_ready);

   assign w_b_valid = (r_w_dir == c_wide) ? wide_rsp_i.b_valid : narrow_rsp_i.b_valid;
   assign w_r_valid = (r_r_dir == c_wide) ? wide_rsp_i.r_valid : narrow_rsp_i.r_valid;
   assign w_r_last  = (r_r_dir == c_wide) ? wide_rsp_i.r.last  : narrow_rsp_i.r.last;

   assign w_aw_hs  = slv_req_i.aw_valid && w_aw_ready;
   assign w_ar_hs  = slv_req_i.ar_valid && w_ar_ready;
   assign w_w_pop  = slv_req_i.w_valid && w_w_ready && slv_req_i.w.last;
   assign w_b_hs   = w_b_valid && slv_req_i.b_ready;
   assign w_r_done = w_r_valid && slv_req_i.r_ready && w_r_last;
   assign w_r_inc  = w_ar_hs || (w_aw_hs && w_aw_atop_rd);

   // Request steering and response merging
   always_comb begin
      narrow_req_o = slv_req_i;
      wide_req_o   = slv_req_i;
      slv_rsp_o    = '0;

      narrow_req_o.aw_valid = slv_req_i.aw_valid && !w_aw_stall && (w_aw_tgt == c_narrow);
      wide_req_o.aw_valid   = slv_req_i.aw_valid && !w_aw_stall && (w_aw_tgt == c_wide);
      narrow_req_o.ar_valid = slv_req_i.ar_valid && !w_ar_stall && (w_ar_tgt == c_narrow);
      wide_req_o.ar_valid   = slv_req_i.ar_valid && !w_ar_stall && (w_ar_tgt == c_wide);
      narrow_req_o.w_valid  = slv_req_i.w_valid && !w_fifo_empty && (w_w_head == c_narrow);
      wide_req_o.w_valid    = slv_req_i.w_valid && !w_fifo_empty && (w_w_head == c_wide);
      narrow_req_o.b_ready  = slv_req_i.b_ready && (r_w_dir == c_narrow);
      wide_req_o.b_ready    = slv_req_i.b_ready && (r_w_dir == c_wide);
      narrow_req_o.r_ready  = slv_req_i.r_ready && (r_r_dir == c_narrow);
      wide_req_o.r_ready    = slv_req_i.r_ready && (r_r_dir == c_wide);

      slv_rsp_o.aw_ready = w_aw_ready;
      slv_rsp_o.ar_ready = w_ar_ready;
      slv_rsp_o.w_ready  = w_w_ready;
      slv_rsp_o.b_valid  = w_b_valid;
      slv_rsp_o.b        = (r_w_dir == c_wide) ? wide_rsp_i.b : narrow_rsp_i.b;
      slv_rsp_o.r_valid  = w_r_valid;
      slv_rsp_o.r        = (r_r_dir == c_wide) ? wide_rsp_i.r : narrow_rsp_i.r;
   end

   // AW-decision FIFO: one target bit per accepted AW, popped on the last W beat
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fifo_mem <= '0;
         r_fifo_wr  <= '0;
         r_fifo_rd  <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_aw_hs) begin
            r_fifo_mem[r_fifo_wr] <= w_aw_tgt;
            r_fifo_wr <= (r_fifo_wr == c_ptr_last) ? '0 : r_fifo_wr + 1'b1;
         end
         if (w_w_pop) begin
            r_fifo_rd <= (r_fifo_rd == c_ptr_last) ? '0 : r_fifo_rd + 1'b1;
         end
         case ({w_aw_hs, w_w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // Outstanding-write counter and write direction; decrement saturates at 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_w_cnt <= '0;
         r_w_dir <= c_narrow;
      end else begin
         if (w_aw_hs) begin
            r_w_dir <= w_aw_tgt;
         end
         case ({w_aw_hs, w_b_hs})
            2'b10:   r_w_cnt <= r_w_cnt + 1'b1;
            2'b01:   r_w_cnt <= (r_w_cnt == '0) ? '0 : r_w_cnt - 1'b1;
            default: r_w_cnt <= r_w_cnt;
         endcase
      end
   end

   // Outstanding-read counter and read direction; ATOPs count as narrow reads
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_r_cnt <= '0;
         r_r_dir <= c_narrow;
      end else begin
         if (w_ar_hs) begin
            r_r_dir <= w_ar_tgt;
         end else if (w_aw_hs && w_aw_atop_rd) begin
            r_r_dir <= c_narrow;
         end
         case ({w_r_inc, w_r_done})
            2'b10:   r_r_cnt <= r_r_cnt + 1'b1;
            2'b01:   r_r_cnt <= (r_r_cnt == '0) ? '0 : r_r_cnt - 1'b1;
            default: r_r_cnt <= r_r_cnt;
         endcase
      end
   end

   // A response with nothing outstanding is a protocol error upstream/downstream.
   a_b_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_b_hs && (r_w_cnt == '0)));
   a_r_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_r_done && (r_r_cnt == '0)));

endmodule

`default_nettype wire

// File: tb/tb_floo_nw_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_floo_nw_split
// Description : Directed self-checking bench for floo_nw_split with a wide
//               window of [0x1000_0000, 0x2000_0000).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_floo_nw_split;

   import floo_nw_split_pkg::*;

   logic     clk;
   logic     rst;
   axi_req_t slv_req;
   axi_rsp_t slv_rsp;
   axi_req_t narrow_req;
   axi_rsp_t narrow_rsp;
   axi_req_t wide_req;
   axi_rsp_t wide_rsp;

   int n_cmp;
   int n_err;

   floo_nw_split #(
      .ADDR_WIDTH   (48),
      .WIDE_START   (48'h0000_1000_0000),
      .WIDE_END     (48'h0000_2000_0000),
      .MAX_TXNS     (8),
      .W_FIFO_DEPTH (4),
      .AXI_REQ_T    (axi_req_t),
      .AXI_RSP_T    (axi_rsp_t)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .slv_req_i    (slv_req),
      .slv_rsp_o    (slv_rsp),
      .narrow_req_o (narrow_req),
      .narrow_rsp_i (narrow_rsp),
      .wide_req_o   (wide_req),
      .wide_rsp_i   (wide_rsp)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence
   initial begin
      n_cmp = 0;
      n_err = 0;
      rst        = 1'b1;
      slv_req    = '0;
      narrow_rsp = '0;
      wide_rsp   = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // ---- Reset state ----
      chk("rst_w_cnt", dut.r_w_cnt, 0);
      chk("rst_r_cnt", dut.r_r_cnt, 0);
      chk("rst_fifo", dut.r_fifo_cnt, 0);
      chk("rst_w_dir", dut.r_w_dir, 0);
      chk("rst_aw_ready", slv_rsp.aw_ready, 0);
      chk("rst_b_valid", slv_rsp.b_valid, 0);
      chk("rst_w_ready", slv_rsp.w_ready, 0);

      // ---- Window boundaries (downstream not ready, so no handshakes) ----
      slv_req.ar_valid = 1'b1;
      slv_req.ar.addr  = 48'h2000_0000;
      #1;
      chk("end_excl_narrow", narrow_req.ar_valid, 1);
      chk("end_excl_wide", wide_req.ar_valid, 0);
      slv_req.ar.addr = 48'h1FFF_FFFF;
      #1;
      chk("end_minus1_wide", wide_req.ar_valid, 1);
      slv_req.ar.addr = 48'h1000_0000;
      #1;
      chk("start_incl_wide", wide_req.ar_valid, 1);
      slv_req.ar.addr = 48'h0FFF_FFFF;
      #1;
      chk("start_minus1_narrow", narrow_req.ar_valid, 1);
      slv_req.ar_valid = 1'b0;

      narrow_rsp.aw_ready = 1'b1; narrow_rsp.w_ready = 1'b1; narrow_rsp.ar_ready = 1'b1;
      wide_rsp.aw_ready   = 1'b1; wide_rsp.w_ready   = 1'b1; wide_rsp.ar_ready   = 1'b1;
      tick();

      // ---- Wide write then narrow write: direction switch and B order ----
      slv_req.aw_valid = 1'b1;
      slv_req.aw.addr  = 48'h1000_0040;
      #1;
      chk("t1_aw_wide_valid", wide_req.aw_valid, 1);
      chk("t1_aw_narrow_valid", narrow_req.aw_valid, 0);
      chk("t1_aw_ready", slv_rsp.aw_ready, 1);
      tick();
      slv_req.aw.addr = 48'h0000_0100;
      slv_req.w_valid = 1'b1; slv_req.w.data = 32'hA1; slv_req.w.last = 1'b1;
      #1;
      chk("t1_aw2_stall", slv_rsp.aw_ready, 0);
      chk("t1_aw2_narrow_off", narrow_req.aw_valid, 0);
      chk("t1_w_to_wide", wide_req.w_valid, 1);
      chk("t1_w_not_narrow", narrow_req.w_valid, 0);
      tick();
      slv_req.w_valid = 1'b0;
      wide_rsp.b_valid = 1'b1;   wide_rsp.b.id = 4'd1;
      narrow_rsp.b_valid = 1'b1; narrow_rsp.b.id = 4'd2;
      slv_req.b_ready = 1'b1;
      #1;
      chk("t1_b1_valid", slv_rsp.b_valid, 1);
      chk("t1_b1_id", slv_rsp.b.id, 1);
      chk("t1_narrow_b_ready", narrow_req.b_ready, 0);
      chk("t1_aw2_still_stall", slv_rsp.aw_ready, 0);
      tick();
      wide_rsp.b_valid = 1'b0;
      #1;
      chk("t1_aw2_go_narrow", narrow_req.aw_valid, 1);
      chk("t1_aw2_ready", slv_rsp.aw_ready, 1);
      chk("t1_b_hidden", slv_rsp.b_valid, 0);
      tick();
      slv_req.aw_valid = 1'b0;
      slv_req.w_valid = 1'b1; slv_req.w.data = 32'hA2; slv_req.w.last = 1'b1;
      #1;
      chk("t1_w2_narrow", narrow_req.w_valid, 1);
      chk("t1_b2_id", slv_rsp.b.id, 2);
      tick();
      slv_req.w_valid = 1'b0; narrow_rsp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
      #1;
      chk("t1_w_cnt_end", dut.r_w_cnt, 0);

      // ---- 8 narrow reads outstanding, 9th stalls ----
      slv_req.ar_valid = 1'b1;
      slv_req.ar.addr  = 48'h0000_0100;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t2_ar_ready", slv_rsp.ar_ready, 1);
         tick();
      end
      chk("t2_ar9_stall", slv_rsp.ar_ready, 0);
      chk("t2_ar9_no_valid", narrow_req.ar_valid, 0);
      chk("t2_r_cnt_max", dut.r_r_cnt, 8);
      tick();
      narrow_rsp.r_valid = 1'b1; narrow_rsp.r.last = 1'b1; narrow_rsp.r.id = 4'd5;
      slv_req.r_ready = 1'b1;
      #1;
      chk("t2_r_valid", slv_rsp.r_valid, 1);
      chk("t2_r_id", slv_rsp.r.id, 5);
      chk("t2_ar9_same_cycle", slv_rsp.ar_ready, 0);
      tick();
      narrow_rsp.r_valid = 1'b0;
      #1;
      chk("t2_ar9_released", slv_rsp.ar_ready, 1);
      tick();
      slv_req.ar_valid = 1'b0;
      narrow_rsp.r_valid = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      narrow_rsp.r_valid = 1'b0; slv_req.r_ready = 1'b0;
      #1;
      chk("t2_r_cnt_drained", dut.r_r_cnt, 0);

      // ---- W presented before its AW ----
      slv_req.w_valid = 1'b1; slv_req.w.data = 32'hB0; slv_req.w.last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_w_held", slv_rsp.w_ready, 0);
         chk("t4_w_not_fwd", narrow_req.w_valid, 0);
         tick();
      end
      slv_req.aw_valid = 1'b1; slv_req.aw.addr = 48'h0000_0200; slv_req.aw.len = 8'd1;
      #1;
      chk("t4_aw_ready", slv_rsp.aw_ready, 1);
      chk("t4_w_push_cycle", slv_rsp.w_ready, 0);
      tick();
      slv_req.aw_valid = 1'b0;
      #1;
      chk("t4_w0_valid", narrow_req.w_valid, 1);
      chk("t4_w0_data", narrow_req.w.data, 32'hB0);
      chk("t4_w0_ready", slv_rsp.w_ready, 1);
      tick();
      slv_req.w.data = 32'hB1; slv_req.w.last = 1'b1;
      #1;
      chk("t4_w1_data", narrow_req.w.data, 32'hB1);
      tick();
      slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
      narrow_rsp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
      #1;
      chk("t4_fifo_empty", dut.r_fifo_cnt, 0);
      chk("t4_b_valid", slv_rsp.b_valid, 1);
      tick();
      narrow_rsp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
      #1;
      chk("t4_w_cnt", dut.r_w_cnt, 0);

      // ---- ATOP at a wide address goes narrow and blocks a wide read ----
      slv_req.aw_valid = 1'b1; slv_req.aw.addr = 48'h1000_0000;
      slv_req.aw.atop = 6'h20; slv_req.aw.len = 8'd0;
      #1;
      chk("t5_atop_narrow", narrow_req.aw_valid, 1);
      chk("t5_atop_not_wide", wide_req.aw_valid, 0);
      chk("t5_atop_ready", slv_rsp.aw_ready, 1);
      tick();
      slv_req.aw_valid = 1'b0; slv_req.aw.atop = 6'h0;
      slv_req.ar_valid = 1'b1; slv_req.ar.addr = 48'h1000_0000;
      slv_req.w_valid = 1'b1; slv_req.w.data = 32'hC0; slv_req.w.last = 1'b1;
      #1;
      chk("t5_w_cnt", dut.r_w_cnt, 1);
      chk("t5_r_cnt", dut.r_r_cnt, 1);
      chk("t5_r_dir", dut.r_r_dir, 0);
      chk("t5_ar_stall", slv_rsp.ar_ready, 0);
      chk("t5_ar_wide_off", wide_req.ar_valid, 0);
      chk("t5_w_narrow", narrow_req.w_valid, 1);
      tick();
      slv_req.w_valid = 1'b0;
      narrow_rsp.r_valid = 1'b1; narrow_rsp.r.last = 1'b1; slv_req.r_ready = 1'b1;
      #1;
      chk("t5_atop_r", slv_rsp.r_valid, 1);
      chk("t5_ar_stall_rlast", slv_rsp.ar_ready, 0);
      tick();
      narrow_rsp.r_valid = 1'b0;
      #1;
      chk("t5_ar_released", slv_rsp.ar_ready, 1);
      chk("t5_ar_wide_on", wide_req.ar_valid, 1);
      tick();
      slv_req.ar_valid = 1'b0;
      wide_rsp.r_valid = 1'b1; wide_rsp.r.last = 1'b1;
      narrow_rsp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
      #1;
      chk("t5_wide_r", slv_rsp.r_valid, 1);
      chk("t5_atop_b", slv_rsp.b_valid, 1);
      tick();
      wide_rsp.r_valid = 1'b0; narrow_rsp.b_valid = 1'b0;
      slv_req.b_ready = 1'b0; slv_req.r_ready = 1'b0;
      #1;
      chk("t5_r_cnt_end", dut.r_r_cnt, 0);
      chk("t5_w_cnt_end", dut.r_w_cnt, 0);

      // ---- Wide bursts: FIFO fills at 4, W beats after the AWs ----
      slv_req.aw_valid = 1'b1; slv_req.aw.len = 8'd3;
      for (int i = 0; i < 4; i++) begin
         slv_req.aw.addr = 48'h1000_0000 + 48'(i * 256);
         #1;
         chk("t3_aw_ready", slv_rsp.aw_ready, 1);
         tick();
      end
      slv_req.aw.addr = 48'h1000_0400;
      #1;
      chk("t3_aw5_stall", slv_rsp.aw_ready, 0);
      chk("t3_fifo_full", dut.r_fifo_cnt, 4);
      chk("t3_w_cnt4", dut.r_w_cnt, 4);
      slv_req.w_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         slv_req.w.data = 32'(i);
         slv_req.w.last = ((i % 4) == 0);
         #1;
         chk("t3_w_wide_valid", wide_req.w_valid, 1);
         chk("t3_w_wide_data", wide_req.w.data, 64'(i));
         if (i <= 5) chk("t3_aw5_ready", slv_rsp.aw_ready, (i == 5) ? 1 : 0);
         tick();
         if (i == 5) slv_req.aw_valid = 1'b0;
      end
      chk("t3_fifo_after", dut.r_fifo_cnt, 3);
      chk("t3_w_cnt5", dut.r_w_cnt, 5);
      for (int i = 1; i <= 4; i++) begin
         slv_req.w.data = 32'(8 + i);
         slv_req.w.last = (i == 4);
         tick();
      end
      slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
      wide_rsp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
      tick();
      tick();
      wide_rsp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
      #1;
      chk("t6_pre_w_cnt", dut.r_w_cnt, 3);
      chk("t6_pre_fifo", dut.r_fifo_cnt, 2);
      chk("t6_pre_w_dir", dut.r_w_dir, 1);

      // ---- Reset mid-operation ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_w_cnt", dut.r_w_cnt, 0);
      chk("t6_r_cnt", dut.r_r_cnt, 0);
      chk("t6_fifo", dut.r_fifo_cnt, 0);
      chk("t6_w_dir", dut.r_w_dir, 0);
      chk("t6_r_dir", dut.r_r_dir, 0);
      chk("t6_w_ready", slv_rsp.w_ready, 0);
      chk("t6_wide_aw_valid", wide_req.aw_valid, 0);
      chk("t6_b_valid", slv_rsp.b_valid, 0);
      chk("t6_r_valid", slv_rsp.r_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
